card_deal_data_path: RTL and testbench

- Datapath stage directly downstream of the seed-random control path in the blackjack dealer.
- Consumes the control path's IDLE/SEND state and, on each IDLE→SEND transition, deals one card from a 52-card deck.
- A card already dealt is never dealt again until the deck is reshuffled.
- Randomness comes from a free-running 16-bit Galois LFSR. Collisions with dealt cards are resolved by a bounded linear probe.

---
 rtl/card_deal_data_path_pkg.sv | 26 ++
 rtl/card_deal_data_path_if.sv | 27 ++
 rtl/card_deal_data_path_lfsr.sv | 19 +
 rtl/card_deal_data_path.sv | 120 ++++++++++++
 tb/tb_card_deal_data_path.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/card_deal_data_path_pkg.sv
// Shared constants, FSM encoding and index helpers for the blackjack card-deal datapath.
package card_pkg;

  localparam int unsigned DECK_SIZE = 52;
  localparam int unsigned RANK_W    = 4;
  localparam int unsigned SUIT_W    = 2;
  localparam int unsigned IDX_W     = 6;

  localparam logic [15:0] DEF_SEED      = 16'hACE1;
  localparam logic [15:0] DEF_LFSR_TAPS = 16'hB400;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_PROBE = 1'b1
  } deal_state_e;

  // Map a raw 6-bit random value (0..63) onto a deck position (0..51).
  function automatic logic [IDX_W-1:0] fold_idx(input logic [IDX_W-1:0] c);
    return (c >= IDX_W'(DECK_SIZE)) ? c - IDX_W'(DECK_SIZE) : c;
  endfunction

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(DECK_SIZE - 1)) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/card_deal_data_path_if.sv
// Bundle between the seed-random control path and the card-deal datapath.
interface card_deal_data_path_if;
  import card_pkg::*;

  logic              state_i;
  logic              shuffle_i;
  logic              card_valid_o;
  logic [IDX_W-1:0]  card_idx_o;
  logic [RANK_W-1:0] card_rank_o;
  logic [SUIT_W-1:0] card_suit_o;
  logic              busy_o;
  logic [IDX_W-1:0]  cards_left_o;
  logic              deck_empty_o;

  modport master (
    output state_i, shuffle_i,
    input  card_valid_o, card_idx_o, card_rank_o, card_suit_o,
           busy_o, cards_left_o, deck_empty_o
  );

  modport slave (
    input  state_i, shuffle_i,
    output card_valid_o, card_idx_o, card_rank_o, card_suit_o,
           busy_o, cards_left_o, deck_empty_o
  );

endinterface

// File: rtl/card_deal_data_path_lfsr.sv
// Free-running 16-bit Galois LFSR, the randomness source for card draws.
module card_lfsr #(
  parameter logic [15:0] SEED = card_pkg::DEF_SEED,
  parameter logic [15:0] TAPS = card_pkg::DEF_LFSR_TAPS
) (
  input  logic        clk_dp_i,
  input  logic        rst_dp_i,
  output logic [15:0] lfsr_o
);

  always_ff @(posedge clk_dp_i) begin
    if (!rst_dp_i) begin
      lfsr_o <= SEED;
    end else begin
      lfsr_o <= (lfsr_o >> 1) ^ (lfsr_o[0] ? TAPS : '0);
    end
  end

endmodule

// File: rtl/card_deal_data_path.sv
// Deals one unique card per IDLE->SEND edge of the control path, probing
// linearly past already-dealt cards until the deck is reshuffled.
module card_deal_data_path
  import card_pkg::*;
#(
  parameter logic [15:0] SEED      = DEF_SEED,
  parameter logic [15:0] LFSR_TAPS = DEF_LFSR_TAPS
) (
  input  logic                   clk_dp_i,
  input  logic                   rst_dp_i,
  card_deal_data_path_if.slave   deal
);

  logic [15:0]          lfsr_q;
  logic                 unused_lfsr_hi;
  deal_state_e          fsm_q, fsm_d;
  logic                 state_q;
  logic                 req;
  logic [DECK_SIZE-1:0] used_q, used_d;
  logic [IDX_W-1:0]     probe_q, probe_d;
  logic [IDX_W-1:0]     left_q, left_d;
  logic                 empty_q, empty_d;
  logic                 valid_q, valid_d;
  logic [IDX_W-1:0]     cidx_q, cidx_d;
  logic [RANK_W-1:0]    rank_q, rank_d;
  logic [SUIT_W-1:0]    suit_q, suit_d;

  card_lfsr #(
    .SEED (SEED),
    .TAPS (LFSR_TAPS)
  ) u_lfsr (
    .clk_dp_i (clk_dp_i),
    .rst_dp_i (rst_dp_i),
    .lfsr_o   (lfsr_q)
  );

  assign unused_lfsr_hi = ^lfsr_q[15:IDX_W];

  assign req = deal.state_i & ~state_q;

  always_comb begin
    fsm_d   = fsm_q;
    used_d  = used_q;
    probe_d = probe_q;
    left_d  = left_q;
    empty_d = empty_q;
    valid_d = 1'b0;
    cidx_d  = cidx_q;
    rank_d  = rank_q;
    suit_d  = suit_q;

    unique case (fsm_q)
      ST_IDLE: begin
        if (deal.shuffle_i) begin
          used_d  = '0;
          left_d  = IDX_W'(DECK_SIZE);
          empty_d = 1'b0;
        end else if (req && (left_q != '0)) begin
          probe_d = fold_idx(lfsr_q[IDX_W-1:0]);
          fsm_d   = ST_PROBE;
        end
      end
      ST_PROBE: begin
        if (deal.shuffle_i) begin
          used_d  = '0;
          left_d  = IDX_W'(DECK_SIZE);
          empty_d = 1'b0;
          fsm_d   = ST_IDLE;
        end else if (used_q[probe_q]) begin
          probe_d = next_idx(probe_q);
        end else begin
          used_d[probe_q] = 1'b1;
          left_d  = left_q - 1'b1;
          empty_d = (left_q == IDX_W'(1));
          valid_d = 1'b1;
          cidx_d  = probe_q;
          rank_d  = probe_q[5:2] + 1'b1;
          suit_d  = probe_q[1:0];
          fsm_d   = ST_IDLE;
        end
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_dp_i) begin
    if (!rst_dp_i) begin
      fsm_q   <= ST_IDLE;
      state_q <= 1'b0;
      used_q  <= '0;
      probe_q <= '0;
      left_q  <= IDX_W'(DECK_SIZE);
      empty_q <= 1'b0;
      valid_q <= 1'b0;
      cidx_q  <= '0;
      rank_q  <= '0;
      suit_q  <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= deal.state_i;
      used_q  <= used_d;
      probe_q <= probe_d;
      left_q  <= left_d;
      empty_q <= empty_d;
      valid_q <= valid_d;
      cidx_q  <= cidx_d;
      rank_q  <= rank_d;
      suit_q  <= suit_d;
    end
  end

  assign deal.card_valid_o = valid_q;
  assign deal.card_idx_o   = cidx_q;
  assign deal.card_rank_o  = rank_q;
  assign deal.card_suit_o  = suit_q;
  assign deal.busy_o       = (fsm_q == ST_PROBE);
  assign deal.cards_left_o = left_q;
  assign deal.deck_empty_o = empty_q;

endmodule

// File: tb/tb_card_deal_data_path.sv
// Directed/randomized bench for card_deal_data_path against a deck-level reference model.
module tb_card_deal_data_path;
  import card_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  card_deal_data_path_if dif ();

  card_deal_data_path #(
    .SEED      (16'hACE1),
    .LFSR_TAPS (16'hB400)
  ) dut (
    .clk_dp_i (clk),
    .rst_dp_i (rst_n),
    .deal     (dif)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_coll   = 0;

  // Reference: the LFSR sequence, the set of dealt cards and the remaining count.
  logic [15:0] m_lfsr;
  bit          used_m [DECK_SIZE];
  bit          seen   [DECK_SIZE];
  int          left_m;

  always @(posedge clk) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < DECK_SIZE; i++) begin
      used_m[i] = 1'b0;
      seen[i]   = 1'b0;
    end
    left_m = DECK_SIZE;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, dif.card_valid_o, 0);
    chk({tag, "_idx"},   dif.card_idx_o,   0);
    chk({tag, "_rank"},  dif.card_rank_o,  0);
    chk({tag, "_suit"},  dif.card_suit_o,  0);
    chk({tag, "_busy"},  dif.busy_o,       0);
    chk({tag, "_left"},  dif.cards_left_o, 52);
    chk({tag, "_empty"}, dif.deck_empty_o, 0);
    chk({tag, "_lfsr"},  dut.u_lfsr.lfsr_o, 16'hACE1);
  endtask

  // One request edge; state_i is held for 'hold' cycles after the pulse.
  task automatic do_req(input int hold);
    logic [5:0] c;
    int idx, probes, lat, extra;
    bit got;
    c = m_lfsr[5:0];
    idx = (c >= 52) ? int'(c) - 52 : int'(c);
    probes = 0;
    dif.state_i = 1'b1;
    if (left_m == 0) begin
      got = 1'b0;
      repeat (hold + 4) begin
        tick();
        if (dif.card_valid_o) got = 1'b1;
      end
      chk("empty_no_pulse", got, 0);
      chk("empty_flag", dif.deck_empty_o, 1);
      chk("empty_left", dif.cards_left_o, 0);
    end else begin
      while (used_m[idx]) begin
        idx = (idx == 51) ? 0 : idx + 1;
        probes++;
      end
      if (probes > 0) n_coll++;
      lat = 0;
      got = 1'b0;
      while (!got && lat < 60) begin
        tick();
        lat++;
        got = dif.card_valid_o;
      end
      chk("pulse_seen", got, 1);
      chk("latency", lat, 2 + probes);
      chk("card_idx", dif.card_idx_o, idx);
      chk("card_rank", dif.card_rank_o, idx / 4 + 1);
      chk("card_suit", dif.card_suit_o, idx % 4);
      chk("cards_left", dif.cards_left_o, left_m - 1);
      chk("deck_empty", dif.deck_empty_o, (left_m == 1) ? 1 : 0);
      chk("distinct", seen[dif.card_idx_o % 52], 0);
      seen[dif.card_idx_o % 52] = 1'b1;
      used_m[idx] = 1'b1;
      left_m--;
      extra = 0;
      repeat (hold) begin
        tick();
        if (dif.card_valid_o) extra++;
      end
      chk("single_pulse", extra, 0);
      chk("idx_hold", dif.card_idx_o, idx);
    end
    dif.state_i = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    dif.state_i   = 1'b0;
    dif.shuffle_i = 1'b0;
    rst_n = 1'b0;
    clear_model();
    repeat (3) tick();
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Single request with SEND held for ten cycles.
    do_req(10);

    // Drain the whole deck, then one request on the empty deck.
    while (left_m > 0) begin
      do_req($urandom_range(1, 3));
      repeat ($urandom_range(0, 3)) tick();
    end
    chk("drained_empty", dif.deck_empty_o, 1);
    chk("drained_left", dif.cards_left_o, 0);
    chk("collisions_seen", (n_coll > 0) ? 1 : 0, 1);
    do_req(2);

    // Shuffle and request in the same IDLE cycle: shuffle wins.
    dif.state_i   = 1'b1;
    dif.shuffle_i = 1'b1;
    tick();
    dif.shuffle_i = 1'b0;
    clear_model();
    chk("shuf_idle_left", dif.cards_left_o, 52);
    chk("shuf_idle_empty", dif.deck_empty_o, 0);
    chk("shuf_idle_busy", dif.busy_o, 0);
    got = 0;
    repeat (4) begin
      tick();
      if (dif.card_valid_o) got++;
    end
    chk("shuf_idle_no_pulse", got, 0);
    dif.state_i = 1'b0;
    tick();

    repeat (6) begin
      do_req($urandom_range(1, 3));
      repeat ($urandom_range(0, 2)) tick();
    end

    // Shuffle while a draw is in progress aborts it.
    dif.state_i = 1'b1;
    tick();
    chk("abort_busy", dif.busy_o, 1);
    dif.shuffle_i = 1'b1;
    tick();
    dif.shuffle_i = 1'b0;
    clear_model();
    chk("abort_valid", dif.card_valid_o, 0);
    chk("abort_left", dif.cards_left_o, 52);
    chk("abort_busy_clr", dif.busy_o, 0);
    got = 0;
    repeat (3) begin
      tick();
      if (dif.card_valid_o) got++;
    end
    chk("abort_no_pulse", got, 0);
    dif.state_i = 1'b0;
    tick();
    do_req(2);

    repeat (4) do_req($urandom_range(1, 3));

    // Reset pulse during a draw.
    dif.state_i = 1'b1;
    tick();
    chk("rst_mid_busy", dif.busy_o, 1);
    rst_n = 1'b0;
    dif.state_i = 1'b0;
    tick();
    chk_reset_outputs("rst_mid");
    rst_n = 1'b1;
    clear_model();
    got = 0;
    repeat (3) begin
      tick();
      if (dif.card_valid_o) got++;
    end
    chk("rst_mid_no_pulse", got, 0);
    repeat (5) do_req($urandom_range(1, 3));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
